// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_t;

endpackage

// File: rtl/fetch_f_if.sv
// Instruction memory request/response bus; fetch is the master.
interface fetch_f_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  IMemReq;
    logic [DATA_WIDTH-1:0] IMemAddr;
    logic                  IMemGnt;
    logic                  IMemRValid;
    logic [DATA_WIDTH-1:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemGnt,
        input  IMemRValid,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemGnt,
        output IMemRValid,
        output IMemRData
    );
endinterface

// File: rtl/fetch_f_pc_reg.sv
// Program counter register: load target, increment by 4, or hold.
module fetch_f_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  pc_sel_t               i_sel,
    input  logic [DATA_WIDTH-1:0] i_target,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus4
);

    logic [DATA_WIDTH-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_sel)
                PC_LOAD: r_pc <= i_target;
                PC_INC:  r_pc <= o_pc_plus4;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + DATA_WIDTH'(4);

endmodule

// File: rtl/fetch_f.sv
// Instruction fetch stage with single-outstanding memory requests and redirect handling.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (align redirect targets, flag misalignment).
module fetch_f
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    fetch_f_if.master             imem,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  ValidF,
    output logic                  InstrMisalignF
);

    fetch_state_t          r_state;
    logic                  r_req;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] w_target;
    pc_sel_t               w_pc_sel;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_target = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_misalign <= 1'b0;
        end else if (PCSrcE) begin
            r_misalign <= |PCTargetE[1:0];
        end
    end

    assign InstrMisalignF = r_misalign;
`else
    assign w_target       = PCTargetE;
    assign InstrMisalignF = 1'b0;
`endif

    // Redirect outranks the consume-increment in every state.
    always_comb begin
        w_pc_sel = PC_HOLD;
        if (PCSrcE) begin
            w_pc_sel = PC_LOAD;
        end else if (r_state == HOLD && !StallF) begin
            w_pc_sel = PC_INC;
        end
    end

    fetch_f_pc_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc_reg (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_sel     (w_pc_sel),
        .i_target  (w_target),
        .o_pc      (PCF),
        .o_pc_plus4(PCPlus4F)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= DATA_WIDTH'(NOP_INSTR);
        end else begin
            r_req <= 1'b0;
            if (PCSrcE) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                end
                REQ: begin
                    if (imem.IMemGnt) begin
                        r_state <= PCSrcE ? DROP : WAIT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.IMemRValid) begin
                        r_state <= PCSrcE ? REQ : HOLD;
                        r_req   <= PCSrcE;
                        if (!PCSrcE) begin
                            r_instr <= imem.IMemRData;
                            r_valid <= 1'b1;
                        end
                    end else if (PCSrcE) begin
                        r_state <= DROP;
                    end
                end
                HOLD: begin
                    if (PCSrcE || !StallF) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem.IMemRValid) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem.IMemReq  = r_req;
    assign imem.IMemAddr = PCF;
    assign ValidF        = r_valid;
    assign InstrF        = r_valid ? r_instr : DATA_WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_fetch_f.sv
// Self-checking bench for fetch_f: directed corner sequences, a redirect vector table,
// and a randomized run against a transaction-level reference model.
module tb_fetch_f;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        InstrMisalignF;

    fetch_f_if #(.DATA_WIDTH(32)) imem_bus ();

    fetch_f #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .StallF        (StallF),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .imem          (imem_bus),
        .InstrF        (InstrF),
        .PCF           (PCF),
        .PCPlus4F      (PCPlus4F),
        .ValidF        (ValidF),
        .InstrMisalignF(InstrMisalignF)
    );

    always #5 CLK = ~CLK;

    int total;
    int bad;

    typedef struct {
        logic [31:0] target;
        logic [31:0] addr;
        logic [31:0] plus4;
        logic        mis;
    } redir_vec_t;

    redir_vec_t vecs[5];

    // Reference model: tracks the fetch address, the single outstanding request and
    // whether it was killed, and the instruction currently offered to decode.
    logic        m_started;
    logic        m_out;
    logic        m_killed;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_mis;

    logic        req_s;
    logic        mem_busy;
    int          mem_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pcf"}, PCF, 32'h0);
        chk({tag, "_pc4"}, PCPlus4F, 32'h4);
        chk({tag, "_valid"}, 32'(ValidF), 32'h0);
        chk({tag, "_instr"}, InstrF, NOP);
        chk({tag, "_req"}, 32'(imem_bus.IMemReq), 32'h0);
        chk({tag, "_mis"}, 32'(InstrMisalignF), 32'h0);
    endtask

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    function automatic logic eff_mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return |t[1:0];
`else
        return 1'b0 & t[0];
`endif
    endfunction

    function automatic logic model_req();
        return m_started && !m_out && !m_valid;
    endfunction

    task automatic model_check();
        logic exp_req;
        exp_req = model_req();
        chk("rand_req", 32'(imem_bus.IMemReq), 32'(exp_req));
        if (exp_req) chk("rand_addr", imem_bus.IMemAddr, m_pc);
        chk("rand_pcf", PCF, m_pc);
        chk("rand_pc4", PCPlus4F, m_pc + 32'd4);
        chk("rand_valid", 32'(ValidF), 32'(m_valid));
        chk("rand_instr", InstrF, m_valid ? m_instr : NOP);
        chk("rand_mis", 32'(InstrMisalignF), 32'(m_mis));
    endtask

    task automatic model_step();
        logic req;
        logic old_valid;
        logic old_out;
        req       = model_req();
        old_valid = m_valid;
        old_out   = m_out;
        if (PCSrcE) begin
            m_valid = 1'b0;
            m_pc    = eff_target(PCTargetE);
            m_mis   = eff_mis(PCTargetE);
        end else if (old_valid && !StallF) begin
            m_valid = 1'b0;
            m_pc    = m_pc + 32'd4;
        end
        if (old_out && imem_bus.IMemRValid) begin
            m_out = 1'b0;
            if (!m_killed && !PCSrcE) begin
                m_valid = 1'b1;
                m_instr = imem_bus.IMemRData;
            end
        end else if (old_out && PCSrcE) begin
            m_killed = 1'b1;
        end
        if (req && imem_bus.IMemGnt) begin
            m_out    = 1'b1;
            m_killed = PCSrcE;
        end
        m_started = 1'b1;
    endtask

    task automatic mem_step();
        if (imem_bus.IMemRValid) mem_busy = 1'b0;
        if (req_s && imem_bus.IMemGnt) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(0, 3);
        end
    endtask

    task automatic drive_random();
        imem_bus.IMemGnt = 1'($urandom_range(0, 1));
        StallF           = ($urandom_range(0, 9) < 3);
        PCSrcE           = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 7))
            0:       PCTargetE = 32'hFFFF_FFFC;
            1:       PCTargetE = $urandom();
            default: PCTargetE = $urandom() & 32'hFFFF_FFFC;
        endcase
        if (mem_busy && mem_cnt == 0) begin
            imem_bus.IMemRValid = 1'b1;
            imem_bus.IMemRData  = $urandom();
        end else begin
            imem_bus.IMemRValid = 1'b0;
            if (mem_busy) mem_cnt--;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        StallF = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = '0;
        imem_bus.IMemGnt    = 1'b0;
        imem_bus.IMemRValid = 1'b0;
        imem_bus.IMemRData  = '0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs[2] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 1'b1};
        vecs[3] = '{32'h0000_0404, 32'h0000_0404, 32'h0000_0408, 1'b0};
        vecs[4] = '{32'h7FFF_FFF3, 32'h7FFF_FFF0, 32'h7FFF_FFF4, 1'b1};
`else
        vecs[2] = '{32'h0000_0102, 32'h0000_0102, 32'h0000_0106, 1'b0};
        vecs[3] = '{32'h0000_0404, 32'h0000_0404, 32'h0000_0408, 1'b0};
        vecs[4] = '{32'h7FFF_FFF3, 32'h7FFF_FFF3, 32'h7FFF_FFF7, 1'b0};
`endif

        cyc(); smp(); chk_reset("rst");

        // First fetch, then a five-cycle stall in HOLD.
        cyc(); RST_N = 1'b1; imem_bus.IMemGnt = 1'b1;
        smp(); chk("idle_req", 32'(imem_bus.IMemReq), 32'h0);
        cyc(); smp();
        chk("first_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("first_addr", imem_bus.IMemAddr, 32'h0);
        cyc();
        imem_bus.IMemGnt = 1'b0; imem_bus.IMemRValid = 1'b1;
        imem_bus.IMemRData = 32'h0050_0093; StallF = 1'b1;
        smp();
        chk("wait_req", 32'(imem_bus.IMemReq), 32'h0);
        chk("wait_valid", 32'(ValidF), 32'h0);
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("hold_valid", 32'(ValidF), 32'h1);
        chk("hold_instr", InstrF, 32'h0050_0093);
        chk("hold_pcf", PCF, 32'h0);
        chk("hold_pc4", PCPlus4F, 32'h4);
        for (int i = 0; i < 5; i++) begin
            cyc(); smp();
            chk("stall_instr", InstrF, 32'h0050_0093);
            chk("stall_valid", 32'(ValidF), 32'h1);
            chk("stall_pcf", PCF, 32'h0);
            chk("stall_req", 32'(imem_bus.IMemReq), 32'h0);
        end
        StallF = 1'b0;
        cyc(); smp();
        chk("next_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("next_addr", imem_bus.IMemAddr, 32'h4);
        chk("next_valid", 32'(ValidF), 32'h0);
        chk("next_instr", InstrF, NOP);

        // Redirect while waiting: the old response must be discarded.
        imem_bus.IMemGnt = 1'b1;
        cyc(); imem_bus.IMemGnt = 1'b0;
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        cyc(); PCSrcE = 1'b0;
        smp();
        chk("drop_req", 32'(imem_bus.IMemReq), 32'h0);
        chk("drop_pcf", PCF, 32'h100);
        imem_bus.IMemRValid = 1'b1; imem_bus.IMemRData = 32'hDEAD_BEEF;
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("drop_valid", 32'(ValidF), 32'h0);
        chk("redir_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("redir_addr", imem_bus.IMemAddr, 32'h100);
        imem_bus.IMemGnt = 1'b1;
        cyc();
        imem_bus.IMemGnt = 1'b0; imem_bus.IMemRValid = 1'b1;
        imem_bus.IMemRData = 32'h0010_0113; StallF = 1'b1;
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("tgt_valid", 32'(ValidF), 32'h1);
        chk("tgt_pcf", PCF, 32'h100);
        chk("tgt_instr", InstrF, 32'h0010_0113);

        // Redirect in HOLD under stall, then redirect coincident with the response.
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        cyc(); PCSrcE = 1'b0;
        smp();
        chk("hstall_valid", 32'(ValidF), 32'h0);
        chk("hstall_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("hstall_addr", imem_bus.IMemAddr, 32'h200);
        imem_bus.IMemGnt = 1'b1;
        cyc();
        imem_bus.IMemGnt = 1'b0; imem_bus.IMemRValid = 1'b1;
        imem_bus.IMemRData = 32'h0BAD_0013; PCSrcE = 1'b1; PCTargetE = 32'h300;
        cyc(); imem_bus.IMemRValid = 1'b0; PCSrcE = 1'b0;
        smp();
        chk("coinc_valid", 32'(ValidF), 32'h0);
        chk("coinc_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("coinc_addr", imem_bus.IMemAddr, 32'h300);
        imem_bus.IMemRValid = 1'b1;
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("stray_valid", 32'(ValidF), 32'h0);
        chk("stray_req", 32'(imem_bus.IMemReq), 32'h1);
        StallF = 1'b0;

        // Redirect target table, applied while sitting in REQ without grant.
        for (int i = 0; i < 5; i++) begin
            PCSrcE = 1'b1; PCTargetE = vecs[i].target;
            cyc(); PCSrcE = 1'b0;
            smp();
            chk("vec_req", 32'(imem_bus.IMemReq), 32'h1);
            chk("vec_addr", imem_bus.IMemAddr, vecs[i].addr);
            chk("vec_pc4", PCPlus4F, vecs[i].plus4);
            chk("vec_mis", 32'(InstrMisalignF), 32'(vecs[i].mis));
        end

        // PC wrap on consume from the top of the address space.
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        cyc(); PCSrcE = 1'b0; imem_bus.IMemGnt = 1'b1;
        smp(); chk("wrap_pc4", PCPlus4F, 32'h0);
        cyc();
        imem_bus.IMemGnt = 1'b0; imem_bus.IMemRValid = 1'b1; imem_bus.IMemRData = 32'h00A0_0093;
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("wrap_valid", 32'(ValidF), 32'h1);
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        cyc(); smp();
        chk("wrap_addr", imem_bus.IMemAddr, 32'h0);
        chk("wrap_next_pc4", PCPlus4F, 32'h4);

        // Asynchronous reset in WAIT; the abandoned response must be ignored.
        imem_bus.IMemGnt = 1'b1;
        cyc(); imem_bus.IMemGnt = 1'b0;
        smp();
        RST_N = 1'b0;
        #1;
        chk_reset("rst_wait");
        cyc();
        RST_N = 1'b1; imem_bus.IMemRValid = 1'b1; imem_bus.IMemRData = 32'hBAD0_BAD0;
        smp();
        chk("rst_idle_valid", 32'(ValidF), 32'h0);
        chk("rst_idle_req", 32'(imem_bus.IMemReq), 32'h0);
        cyc(); smp();
        chk("rst_req_valid", 32'(ValidF), 32'h0);
        chk("rst_req", 32'(imem_bus.IMemReq), 32'h1);
        chk("rst_req_addr", imem_bus.IMemAddr, 32'h0);
        cyc(); imem_bus.IMemRValid = 1'b0;
        smp();
        chk("rst_stray_valid", 32'(ValidF), 32'h0);
        chk("rst_stray_req", 32'(imem_bus.IMemReq), 32'h1);

        // Randomized run against the reference model.
        RST_N = 1'b0;
        imem_bus.IMemGnt = 1'b0; imem_bus.IMemRValid = 1'b0;
        PCSrcE = 1'b0; StallF = 1'b0;
        cyc();
        m_started = 1'b0; m_out = 1'b0; m_killed = 1'b0; m_valid = 1'b0;
        m_instr = '0; m_pc = 32'h0; m_mis = 1'b0;
        mem_busy = 1'b0; mem_cnt = 0;
        RST_N = 1'b1;
        drive_random();
        for (int c = 0; c < 2000; c++) begin
            smp();
            model_check();
            req_s = imem_bus.IMemReq;
            @(posedge CLK);
            model_step();
            mem_step();
            #1;
            drive_random();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
